matrix_strip_multi: RTL and testbench

- Parametrised successor to the single-strip matrix driver.
- Drives CHANNELS clocked-serial LED matrices (ROWS x COLS pixels each) from one shared strip clock, one data line per channel, and one shared latch.
- Each channel shows one decimal-digit glyph. The glyph advances on a synchronised button input or automatically every AUTO_FRAMES frames.
- Sits directly behind the io_in/io_out pin wrapper.

---
 rtl/matrix_strip_multi_pkg.sv | 36 +++
 rtl/matrix_strip_multi_btn_sync.sv | 31 +++
 rtl/matrix_strip_multi.sv | 166 ++++++++++++++++
 tb/tb_matrix_strip_multi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_strip_multi_pkg.sv
// Shared types and constants for the multi-channel LED matrix strip driver:
// digit glyph bitmaps, FSM states and the digit counter width.
package matrix_strip_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  // 10 digits x 8 rows; byte MSB is column 0, first byte is row 0.
  localparam logic [0:9][0:7][7:0] GLYPH = {
    64'h3C666E7666663C00,  // 0
    64'h1838181818187E00,  // 1
    64'h3C66060C30607E00,  // 2
    64'h3C66061C06663C00,  // 3
    64'h0C1C3C6C7E0C0C00,  // 4
    64'h7E607C0606663C00,  // 5
    64'h3C607C6666663C00,  // 6
    64'h7E060C1830303000,  // 7
    64'h3C66663C66663C00,  // 8
    64'h3C66663E060C3800   // 9
  };

  function automatic logic glyph_pixel(input logic [DIGIT_W-1:0] d,
                                       input logic [2:0] row,
                                       input logic [2:0] col);
    logic [7:0] bits;
    bits = (d <= DIGIT_W'(9)) ? GLYPH[d][row] : 8'h00;
    return bits[3'd7 - col];
  endfunction

endpackage

// File: rtl/matrix_strip_multi_btn_sync.sv
// Per-channel button path: 2-FF synchroniser, rising-edge detect and a
// mod-10 digit counter that also accepts a shared auto-advance strobe.
module matrix_btn_sync
  import matrix_strip_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic               auto_inc,
  output logic [DIGIT_W-1:0] value
);

  logic [2:0] sync;
  logic       rise;
  logic       inc;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], btn};
  end

  assign rise = sync[1] & ~sync[2];
  // A press and an auto strobe in the same clk still count as one step.
  assign inc  = rise | auto_inc;

  always_ff @(posedge clk) begin
    if (rst)                     value <= '0;
    else if (inc)                value <= (value == DIGIT_W'(9)) ? '0 : value + 1'b1;
  end

endmodule

// File: rtl/matrix_strip_multi.sv
// Multi-channel serial LED matrix driver: shared clock and latch, one data
// line per channel, each channel showing its own decimal digit glyph.
module matrix_strip_multi
  import matrix_strip_pkg::*;
#(
  parameter int MAX_COUNT   = 100,
  parameter int CHANNELS    = 2,
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int GAP_TICKS   = 4,
  parameter int AUTO_FRAMES = 16,
  parameter int SERPENTINE  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] digit,
  input  logic                mode,
  output logic                strip_clk,
  output logic [CHANNELS-1:0] strip_data,
  output logic                strip_latch,
  output logic                frame_done
);

  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8) begin : g_bad_dims
    $error("matrix_strip_multi: ROWS and COLS must be in 1..8");
  end

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(MAX_COUNT - 1);
  localparam logic [GW-1:0] LAST_GAP   = GW'(GAP_TICKS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(AUTO_FRAMES - 1);
  localparam logic [2:0]    LAST_ROW   = 3'(ROWS - 1);
  localparam logic [2:0]    LAST_COL   = 3'(COLS - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  state_t        state, state_n;
  logic [2:0]    row, row_n, col, col_n, col_eff;
  logic [GW-1:0] gcnt, gcnt_n;
  logic          load_shadow;
  logic          left_latch;

  logic [FW-1:0]                      fcnt;
  logic                               auto_inc;
  logic [CHANNELS-1:0][DIGIT_W-1:0]   digit_val;
  logic [CHANNELS-1:0][DIGIT_W-1:0]   shadow;
  logic [CHANNELS-1:0]                pix;

  // Tick prescaler
  assign tick = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    matrix_btn_sync u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn      (digit[c]),
      .auto_inc (auto_inc),
      .value    (digit_val[c])
    );
  end

  // Auto advance: count frames while mode=1, strobe all channels on wrap.
  assign auto_inc = mode && frame_done && (fcnt == LAST_FRAME);

  always_ff @(posedge clk) begin
    if (rst || !mode)   fcnt <= '0;
    else if (frame_done) fcnt <= auto_inc ? '0 : fcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHIFT_LO;
      row   <= '0;
      col   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      gcnt  <= gcnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    row_n       = row;
    col_n       = col;
    gcnt_n      = gcnt;
    load_shadow = 1'b0;
    if (tick) begin
      case (state)
        SHIFT_LO: state_n = SHIFT_HI;
        SHIFT_HI: begin
          if (row == LAST_ROW && col == LAST_COL) begin
            state_n = LATCH;
          end else begin
            state_n = SHIFT_LO;
            if (col == LAST_COL) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        end
        LATCH: begin
          row_n  = '0;
          col_n  = '0;
          gcnt_n = '0;
          if (GAP_TICKS == 0) begin
            state_n     = SHIFT_LO;
            load_shadow = 1'b1;
          end else begin
            state_n = GAP;
          end
        end
        GAP: begin
          if (gcnt == LAST_GAP) begin
            state_n     = SHIFT_LO;
            load_shadow = 1'b1;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Digits are frozen for the whole frame so a press never tears a glyph.
  always_ff @(posedge clk) begin
    if (rst)              shadow <= '0;
    else if (load_shadow) shadow <= digit_val;
  end

  assign col_eff = ((SERPENTINE != 0) && row[0]) ? (LAST_COL - col) : col;

  always_comb begin
    pix = '0;
    for (int c = 0; c < CHANNELS; c++) pix[c] = glyph_pixel(shadow[c], row, col_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strip_clk   <= 1'b0;
      strip_data  <= '0;
      strip_latch <= 1'b0;
      left_latch  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      strip_clk   <= (state == SHIFT_HI);
      strip_data  <= (state == SHIFT_LO || state == SHIFT_HI) ? pix : '0;
      strip_latch <= (state == LATCH);
      left_latch  <= tick && (state == LATCH);
      frame_done  <= left_latch;
    end
  end

endmodule

// File: tb/tb_matrix_strip_multi.sv
// Scoreboard bench: stimulus queues the expected digits of each frame, a
// monitor reassembles frames from the serial lines and checks them.
`timescale 1ns/1ps
module tb_matrix_strip_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] digit;
  logic       mode;
  logic       s_clk, s_latch, s_done;
  logic [1:0] s_data;
  logic       p_clk, p_latch, p_done;
  logic [1:0] p_data;

  typedef struct { int d0; int d1; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int nb = 0;
  int frames = 0;
  int m0 = 0, m1 = 0;
  logic [63:0] frm [2];
  logic [63:0] sfrm [2];
  logic prev_clk = 1'b0, prev_latch = 1'b0;

  always #5 clk = ~clk;

  matrix_strip_multi #(.MAX_COUNT(2), .CHANNELS(2), .ROWS(8), .COLS(8),
    .GAP_TICKS(4), .AUTO_FRAMES(2), .SERPENTINE(0)) dut (
    .clk(clk), .rst(rst), .digit(digit), .mode(mode), .strip_clk(s_clk),
    .strip_data(s_data), .strip_latch(s_latch), .frame_done(s_done));

  matrix_strip_multi #(.MAX_COUNT(2), .CHANNELS(2), .ROWS(8), .COLS(8),
    .GAP_TICKS(4), .AUTO_FRAMES(2), .SERPENTINE(1)) dut_serp (
    .clk(clk), .rst(rst), .digit(digit), .mode(mode), .strip_clk(p_clk),
    .strip_data(p_data), .strip_latch(p_latch), .frame_done(p_done));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] glyph64(int d);
    case (d)
      0: return 64'h3C666E7666663C00;
      1: return 64'h1838181818187E00;
      2: return 64'h3C66060C30607E00;
      3: return 64'h3C66061C06663C00;
      4: return 64'h0C1C3C6C7E0C0C00;
      5: return 64'h7E607C0606663C00;
      6: return 64'h3C607C6666663C00;
      7: return 64'h7E060C1830303000;
      8: return 64'h3C66663C66663C00;
      9: return 64'h3C66663E060C3800;
      default: return 64'h0;
    endcase
  endfunction

  // Odd rows arrive column 7 first, so their captured bytes are bit-reversed.
  function automatic logic [63:0] serp64(int d);
    logic [63:0] g, r;
    g = glyph64(d);
    r = g;
    for (int row = 1; row < 8; row += 2)
      for (int b = 0; b < 8; b++) r[63 - 8*row - b] = g[63 - 8*row - (7 - b)];
    return r;
  endfunction

  task automatic push_exp(int d0, int d1);
    exp_t e;
    e.d0 = d0;
    e.d1 = d1;
    q.push_back(e);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_done && n < 600);
    chk("frame_done_wait", s_done, 1);
  endtask

  task automatic press(int ch, int len);
    digit[ch] = 1'b1;
    repeat (len) @(negedge clk);
    digit[ch] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Monitor: rebuild each frame from rising strip_clk and score it at latch.
  always @(negedge clk) begin
    if (rst) begin
      nb = 0;
      prev_clk = 1'b0;
      prev_latch = 1'b0;
    end else begin
      if (s_clk && !prev_clk) begin
        for (int c = 0; c < 2; c++) begin
          frm[c]  = {frm[c][62:0], s_data[c]};
          sfrm[c] = {sfrm[c][62:0], p_data[c]};
        end
        nb++;
      end
      if (s_latch && !prev_latch) begin
        exp_t e;
        frames++;
        chk("bits_per_frame", nb, 64);
        chk("serp_latch_align", p_latch, 1);
        chk("expect_avail", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("frame%0d_ch0", frames), frm[0], glyph64(e.d0));
          chk($sformatf("frame%0d_ch1", frames), frm[1], glyph64(e.d1));
          chk($sformatf("frame%0d_serp_ch0", frames), sfrm[0], serp64(e.d0));
          chk($sformatf("frame%0d_serp_ch1", frames), sfrm[1], serp64(e.d1));
          if (e.d0 == 1) chk("serp_row1_digit1", sfrm[0][55:48], 8'h1C);
        end
        nb = 0;
      end
      prev_clk = s_clk;
      prev_latch = s_latch;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] row0_bits;
    row0_bits = 8'b00111100;
    rst = 1'b1; digit = 2'b00; mode = 1'b0;
    push_exp(0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("reset_outputs", {s_clk, s_data, s_latch, s_done, p_clk, p_data, p_latch, p_done}, 0);
    end
    rst = 1'b0;

    // First frame: exact clk-level shape of clock, data, latch and done.
    for (int k = 0; k <= 258; k++) begin
      logic [63:0] g;
      logic ec, ed;
      @(negedge clk);
      g  = glyph64(0);
      ec = (k < 256) && ((k % 4) >= 2);
      ed = (k < 256) ? g[63 - k/4] : 1'b0;
      chk($sformatf("frame1_k%0d", k), {s_clk, s_latch, s_done, s_data},
          {ec, k == 256 || k == 257, k == 258, ed, ed});
      if (k < 32 && (k % 4) == 2) chk($sformatf("ch0_bit%0d", k/4), s_data[0], row0_bits[7 - k/4]);
    end

    push_exp(0, 0);                       // F2: press mid-frame must not alter it
    repeat (20) @(negedge clk);
    press(0, 10); m0 = 1;
    wait_fd(n); push_exp(m0, m1);         // F3
    repeat (20) @(negedge clk);
    fork begin digit[0] = 1'b1; repeat (500) @(negedge clk); digit[0] = 1'b0; end join_none
    m0 = 2;
    wait_fd(n); push_exp(m0, m1);         // F4
    wait_fd(n); push_exp(m0, m1);         // F5: long hold gave a single step
    repeat (20) @(negedge clk);
    repeat (9) press(1, 10);
    m1 = 9;
    wait_fd(n); push_exp(m0, m1);         // F6
    repeat (20) @(negedge clk);
    press(1, 10); m1 = 0;
    wait_fd(n); push_exp(m0, m1);         // F7
    repeat (20) @(negedge clk);
    mode = 1'b1;
    wait_fd(n); push_exp(m0, m1);         // F8
    wait_fd(n); m0 = 3; m1 = 1; push_exp(m0, m1);  // F9 after auto step
    wait_fd(n); push_exp(m0, m1);         // F10
    repeat (264) @(negedge clk);
    digit[0] = 1'b1;                      // edge lands in the auto-step clk
    wait_fd(n);
    chk("coincide_align", n, 2);
    m0 = 4; m1 = 2; push_exp(m0, m1);     // F11
    repeat (10) @(negedge clk);
    digit[0] = 1'b0;
    repeat (10) @(negedge clk);
    mode = 1'b0;
    wait_fd(n); push_exp(m0, m1);         // F12
    wait_fd(n); push_exp(m0, m1);         // F13: mode=0 holds digits

    wait_fd(n);                           // F14 is aborted by reset
    repeat (90) @(negedge clk);
    #1;
    chk("pre_rst_clk_high", s_clk, 1);
    chk("pre_rst_bit_count", nb, 21);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_outputs", {s_clk, s_latch, s_done, s_data, p_clk, p_latch}, 0);
    repeat (3) @(negedge clk);
    m0 = 0; m1 = 0; push_exp(m0, m1);
    rst = 1'b0;
    wait_fd(n);
    chk("restart_fd_latency", n, 259);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("frames_seen", frames, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
